// File: rtl/axi4_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4_wr_arbiter : round-robin AW/W arbiter over one AXI4 write slave, B routed by grant FIFO
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module axi4_wr_arbiter #(
    parameter int NUM_MST = 4,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int OUTSTD  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MST-1:0]          m_awvalid_i,
    output logic [NUM_MST-1:0]          m_awready_o,
    input  logic [NUM_MST*ID_W-1:0]     m_awid_i,
    input  logic [NUM_MST*ADDR_W-1:0]   m_awaddr_i,
    input  logic [NUM_MST*8-1:0]        m_awlen_i,
    input  logic [NUM_MST*3-1:0]        m_awsize_i,
    input  logic [NUM_MST*2-1:0]        m_awburst_i,
    input  logic [NUM_MST-1:0]          m_wvalid_i,
    output logic [NUM_MST-1:0]          m_wready_o,
    input  logic [NUM_MST*DATA_W-1:0]   m_wdata_i,
    input  logic [NUM_MST*DATA_W/8-1:0] m_wstrb_i,
    input  logic [NUM_MST-1:0]          m_wlast_i,
    output logic [NUM_MST-1:0]          m_bvalid_o,
    input  logic [NUM_MST-1:0]          m_bready_i,
    output logic [ID_W-1:0]             m_bid_o,
    output logic [1:0]                  m_bresp_o,
    output logic                        s_awvalid_o,
    input  logic                        s_awready_i,
    output logic [ID_W-1:0]             s_awid_o,
    output logic [ADDR_W-1:0]           s_awaddr_o,
    output logic [7:0]                  s_awlen_o,
    output logic [2:0]                  s_awsize_o,
    output logic [1:0]                  s_awburst_o,
    output logic                        s_wvalid_o,
    input  logic                        s_wready_i,
    output logic [DATA_W-1:0]           s_wdata_o,
    output logic [DATA_W/8-1:0]         s_wstrb_o,
    output logic                        s_wlast_o,
    input  logic                        s_bvalid_i,
    output logic                        s_bready_o,
    input  logic [ID_W-1:0]             s_bid_i,
    input  logic [1:0]                  s_bresp_i,
    output logic                        err_o
);

    localparam int GW = $clog2(NUM_MST);
    localparam int PW = $clog2(OUTSTD);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [1:0]    BURST_WRAP = 2'b10;
    localparam logic [1:0]    BURST_RSVD = 2'b11;
    localparam logic [GW-1:0] LAST_MST   = GW'(NUM_MST - 1);
    localparam logic [PW:0]   CNT_FULL   = (PW+1)'(OUTSTD);

    logic [1:0]    state;
    logic [GW-1:0] grant;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] next_grant;
    logic [GW-1:0] fifo_mem [OUTSTD];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [7:0]    beat_cnt;
    logic [7:0]    awlen_q;
    logic          err;

    logic          in_addr;
    logic          in_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [GW-1:0] head;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;
    logic          aw_err;
    logic          w_err;
    logic          wrap_len_ok;

    // First requester at or after rr_ptr, wrapping around NUM_MST.
    always_comb begin
        logic [GW:0] sum;
        logic        found;
        next_grant = rr_ptr;
        found      = 1'b0;
        sum        = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            sum = {1'b0, rr_ptr} + (GW+1)'(i);
            if (sum >= (GW+1)'(NUM_MST)) begin
                sum = sum - (GW+1)'(NUM_MST);
            end
            if (!found && m_awvalid_i[sum[GW-1:0]]) begin
                next_grant = sum[GW-1:0];
                found      = 1'b1;
            end
        end
    end

    assign in_addr    = (state == S_ADDR);
    assign in_data    = (state == S_DATA);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign head       = fifo_mem[rd_ptr];

    assign s_awid_o    = m_awid_i[int'(grant)*ID_W +: ID_W];
    assign s_awaddr_o  = m_awaddr_i[int'(grant)*ADDR_W +: ADDR_W];
    assign s_awlen_o   = m_awlen_i[int'(grant)*8 +: 8];
    assign s_awsize_o  = m_awsize_i[int'(grant)*3 +: 3];
    assign s_awburst_o = m_awburst_i[int'(grant)*2 +: 2];
    assign s_awvalid_o = in_addr & m_awvalid_i[grant];
    assign m_awready_o = in_addr ? (NUM_MST'(s_awready_i) << grant) : '0;

    // W from the granted master is only visible once its AW has been accepted.
    assign s_wdata_o  = m_wdata_i[int'(grant)*DATA_W +: DATA_W];
    assign s_wstrb_o  = m_wstrb_i[int'(grant)*(DATA_W/8) +: (DATA_W/8)];
    assign s_wvalid_o = in_data & m_wvalid_i[grant];
    assign s_wlast_o  = in_data & (beat_cnt == awlen_q);
    assign m_wready_o = in_data ? (NUM_MST'(s_wready_i) << grant) : '0;

    assign m_bid_o    = s_bid_i;
    assign m_bresp_o  = s_bresp_i;
    assign s_bready_o = !fifo_empty & m_bready_i[head];
    assign m_bvalid_o = fifo_empty ? '0 : (NUM_MST'(s_bvalid_i) << head);

    assign aw_hs = s_awvalid_o & s_awready_i;
    assign w_hs  = s_wvalid_o & s_wready_i;
    assign b_hs  = s_bvalid_i & s_bready_o;

    assign wrap_len_ok = (s_awlen_o == 8'd1) || (s_awlen_o == 8'd3) ||
                         (s_awlen_o == 8'd7) || (s_awlen_o == 8'd15);
    assign aw_err = (s_awburst_o == BURST_RSVD) ||
                    ((s_awburst_o == BURST_WRAP) && !wrap_len_ok);
    assign w_err  = (m_wlast_i[grant] != s_wlast_o);
    assign err_o  = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            awlen_q  <= '0;
            err      <= 1'b0;
        end else begin
            err <= err | (aw_hs & aw_err) | (w_hs & w_err);
            case (state)
                S_IDLE: begin
                    if (|m_awvalid_i && !fifo_full) begin
                        grant <= next_grant;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (aw_hs) begin
                        awlen_q  <= s_awlen_o;
                        rr_ptr   <= (grant == LAST_MST) ? '0 : grant + GW'(1);
                        beat_cnt <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == awlen_q) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Grant-order FIFO: push on AW acceptance, pop on B handshake.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            fifo_mem[wr_ptr] <= grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (aw_hs) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (b_hs) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({aw_hs, b_hs})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi4_wr_arbiter : directed vector bench for axi4_wr_arbiter
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_axi4_wr_arbiter;

    localparam int NM = 4;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int OS = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_awvalid_i, m_awready_o;
    logic [NM*IW-1:0]  m_awid_i;
    logic [NM*AW-1:0]  m_awaddr_i;
    logic [NM*8-1:0]   m_awlen_i;
    logic [NM*3-1:0]   m_awsize_i;
    logic [NM*2-1:0]   m_awburst_i;
    logic [NM-1:0]     m_wvalid_i, m_wready_o;
    logic [NM*DW-1:0]  m_wdata_i;
    logic [NM*DW/8-1:0] m_wstrb_i;
    logic [NM-1:0]     m_wlast_i;
    logic [NM-1:0]     m_bvalid_o, m_bready_i;
    logic [IW-1:0]     m_bid_o;
    logic [1:0]        m_bresp_o;
    logic              s_awvalid_o, s_awready_i;
    logic [IW-1:0]     s_awid_o;
    logic [AW-1:0]     s_awaddr_o;
    logic [7:0]        s_awlen_o;
    logic [2:0]        s_awsize_o;
    logic [1:0]        s_awburst_o;
    logic              s_wvalid_o, s_wready_i;
    logic [DW-1:0]     s_wdata_o;
    logic [DW/8-1:0]   s_wstrb_o;
    logic              s_wlast_o;
    logic              s_bvalid_i, s_bready_o;
    logic [IW-1:0]     s_bid_i;
    logic [1:0]        s_bresp_i;
    logic              err_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         mst;
        logic [7:0] len;
        logic [1:0] burst;
        logic [31:0] addr;
        int         bad_beat;
        logic       aw_err;
    } vec_t;

    vec_t vecs [7];

    axi4_wr_arbiter #(
        .NUM_MST(NM), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .OUTSTD(OS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_awvalid_i(m_awvalid_i), .m_awready_o(m_awready_o),
        .m_awid_i(m_awid_i), .m_awaddr_i(m_awaddr_i), .m_awlen_i(m_awlen_i),
        .m_awsize_i(m_awsize_i), .m_awburst_i(m_awburst_i),
        .m_wvalid_i(m_wvalid_i), .m_wready_o(m_wready_o),
        .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i), .m_wlast_i(m_wlast_i),
        .m_bvalid_o(m_bvalid_o), .m_bready_i(m_bready_i),
        .m_bid_o(m_bid_o), .m_bresp_o(m_bresp_o),
        .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
        .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o), .s_awlen_o(s_awlen_o),
        .s_awsize_o(s_awsize_o), .s_awburst_o(s_awburst_o),
        .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wlast_o(s_wlast_o),
        .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o),
        .s_bid_i(s_bid_i), .s_bresp_i(s_bresp_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NM-1:0] v);
        int r;
        r = -1;
        for (int i = NM - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic clear_inputs();
        m_awvalid_i = '0;
        m_awid_i    = '0;
        m_awaddr_i  = '0;
        m_awlen_i   = '0;
        m_awsize_i  = {NM{3'd3}};
        m_awburst_i = {NM{2'b01}};
        m_wvalid_i  = '0;
        m_wdata_i   = '0;
        m_wstrb_i   = '1;
        m_wlast_i   = '0;
        m_bready_i  = '1;
        s_awready_i = 1'b1;
        s_wready_i  = 1'b1;
        s_bvalid_i  = 1'b0;
        s_bid_i     = '0;
        s_bresp_i   = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Full AW -> W -> B transaction from one master, checking every stage.
    task automatic do_write(input vec_t v);
        int         m;
        logic [63:0] d;
        logic       exp_err;
        m = v.mst;
        m_awvalid_i[m]           = 1'b1;
        m_awid_i[m*IW +: IW]     = IW'(m + 8);
        m_awaddr_i[m*AW +: AW]   = v.addr;
        m_awlen_i[m*8 +: 8]      = v.len;
        m_awburst_i[m*2 +: 2]    = v.burst;
        m_wvalid_i[m]            = 1'b1;
        m_wdata_i[m*DW +: DW]    = {16'hDA7A, 16'(m), 32'd0};
        m_wlast_i[m]             = (v.len == 8'd0) || (v.bad_beat == 0);
        #1;
        chk("idle_no_awvalid", s_awvalid_o, 0);
        tick();
        chk("aw_valid", s_awvalid_o, 1);
        chk("aw_addr", s_awaddr_o, v.addr);
        chk("aw_len", s_awlen_o, v.len);
        chk("aw_burst", s_awburst_o, v.burst);
        chk("aw_size", s_awsize_o, 3);
        chk("aw_id", s_awid_o, m + 8);
        chk("aw_ready", m_awready_o, 1 << m);
        chk("early_w_held", {m_wready_o, s_wvalid_o}, 0);
        tick();
        m_awvalid_i[m] = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            d = {16'hDA7A, 16'(m), 32'(b)};
            m_wdata_i[m*DW +: DW] = d;
            m_wlast_i[m] = (b == int'(v.len)) || (b == v.bad_beat);
            exp_err = v.aw_err || (v.bad_beat >= 0 && b > v.bad_beat);
            #1;
            chk("w_valid", s_wvalid_o, 1);
            chk("w_data", s_wdata_o, d);
            chk("w_last", s_wlast_o, (b == int'(v.len)) ? 1 : 0);
            chk("w_ready", m_wready_o, 1 << m);
            chk("err_during_burst", err_o, exp_err);
            tick();
        end
        m_wvalid_i[m] = 1'b0;
        m_wlast_i[m]  = 1'b0;
        s_bvalid_i    = 1'b1;
        s_bid_i       = IW'(m + 8);
        s_bresp_i     = 2'b00;
        #1;
        chk("b_valid_route", m_bvalid_o, 1 << m);
        chk("b_id", m_bid_o, m + 8);
        chk("b_resp", m_bresp_o, 0);
        chk("b_ready", s_bready_o, 1);
        tick();
        s_bvalid_i = 1'b0;
        #1;
        chk("b_empty_after_pop", {s_bready_o, m_bvalid_o}, 0);
        chk("err_final", err_o, v.aw_err || (v.bad_beat >= 0));
    endtask

    initial begin
        int order [8];
        int ng;
        int g5;
        int exp_b [4];

        vecs[0] = '{mst: 1, len: 8'd3,  burst: 2'b01, addr: 32'h0000_0100, bad_beat: -1, aw_err: 1'b0};
        vecs[1] = '{mst: 0, len: 8'd0,  burst: 2'b01, addr: 32'h0000_2000, bad_beat: -1, aw_err: 1'b0};
        vecs[2] = '{mst: 2, len: 8'd7,  burst: 2'b10, addr: 32'h0000_0040, bad_beat: -1, aw_err: 1'b0};
        vecs[3] = '{mst: 3, len: 8'd2,  burst: 2'b10, addr: 32'h0000_0080, bad_beat: -1, aw_err: 1'b1};
        vecs[4] = '{mst: 0, len: 8'd1,  burst: 2'b11, addr: 32'h0000_0010, bad_beat: -1, aw_err: 1'b1};
        vecs[5] = '{mst: 1, len: 8'd3,  burst: 2'b01, addr: 32'h0000_0300, bad_beat: 1,  aw_err: 1'b0};
        vecs[6] = '{mst: 2, len: 8'd15, burst: 2'b00, addr: 32'hABCD_0000, bad_beat: -1, aw_err: 1'b0};

        // Reset state with every input trying to provoke an output.
        clear_inputs();
        rst_n = 1'b0;
        m_awvalid_i = '1;
        m_wvalid_i  = '1;
        s_bvalid_i  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awvalid", s_awvalid_o, 0);
        chk("rst_awready", m_awready_o, 0);
        chk("rst_wvalid", s_wvalid_o, 0);
        chk("rst_wready", m_wready_o, 0);
        chk("rst_bvalid", m_bvalid_o, 0);
        chk("rst_bready", s_bready_o, 0);
        chk("rst_err", err_o, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            do_write(vecs[i]);
        end

        // Fairness: all masters request len=0 continuously.
        do_reset();
        m_awvalid_i = '1;
        m_wvalid_i  = '1;
        m_wlast_i   = '1;
        s_bvalid_i  = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            #1;
            if (s_awvalid_o && s_awready_i) begin
                order[ng] = onehot_idx(m_awready_o);
                ng++;
            end
            tick();
        end
        chk("fair_grant_count", ng, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fair_order_%0d", k), order[k], k % NM);
        end

        // Back-pressure: B withheld, FIFO fills at OS grants.
        do_reset();
        m_awvalid_i = '1;
        m_wvalid_i  = '1;
        m_wlast_i   = '1;
        ng = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (s_awvalid_o && s_awready_i) begin
                if (ng < 8) order[ng] = onehot_idx(m_awready_o);
                ng++;
            end
            tick();
        end
        chk("bp_accepted", ng, OS);
        for (int k = 0; k < OS; k++) begin
            chk($sformatf("bp_order_%0d", k), order[k], k);
        end
        #1;
        chk("bp_stalled", {s_awvalid_o, m_awready_o}, 0);
        s_bvalid_i = 1'b1;
        #1;
        chk("bp_first_b", m_bvalid_o, 4'b0001);
        chk("bp_first_bready", s_bready_o, 1);
        tick();
        s_bvalid_i = 1'b0;
        g5 = -1;
        for (int c = 0; c < 6 && g5 < 0; c++) begin
            #1;
            if (s_awvalid_o && s_awready_i) g5 = onehot_idx(m_awready_o);
            tick();
        end
        m_awvalid_i = '0;
        chk("bp_fifth_grant", g5, 0);
        tick();
        tick();
        exp_b = '{1, 2, 3, 0};
        s_bvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp_b_order_%0d", k), m_bvalid_o, 1 << exp_b[k]);
            tick();
        end
        s_bvalid_i = 1'b0;
        #1;
        chk("bp_drained", m_bvalid_o, 0);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        m_awvalid_i[2]      = 1'b1;
        m_awlen_i[2*8 +: 8] = 8'd3;
        tick();
        tick();
        m_awvalid_i[2] = 1'b0;
        m_wvalid_i[2]  = 1'b1;
        tick();
        s_bvalid_i = 1'b1;
        #2;
        chk("mid_w_active", {s_wvalid_o, m_wready_o}, {1'b1, 4'b0100});
        chk("mid_b_active", m_bvalid_o, 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w", {s_wvalid_o, m_wready_o, s_wlast_o}, 0);
        chk("mid_rst_aw", {s_awvalid_o, m_awready_o}, 0);
        chk("mid_rst_b", {s_bready_o, m_bvalid_o}, 0);
        clear_inputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        m_awvalid_i[3] = 1'b1;
        #1;
        chk("post_rst_idle", s_awvalid_o, 0);
        tick();
        chk("post_rst_grant", {s_awvalid_o, m_awready_o}, {1'b1, 4'b1000});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_wr_arbiter.md
Name: axi4_wr_arbiter

Overview:
- Round-robin arbiter that shares one AXI4 write slave between NUM_MST masters.
- Grants the AW channel to one master at a time and locks W to that master until its burst's final beat.
- Records grant order in a FIFO so B responses return to the issuing master.
- Sits between masters and a shared memory/peripheral port; uses the package AXI4 size/burst/resp encodings.

Parameters:
- NUM_MST, 4, number of upstream masters (2..8)
- ID_W, 4, AXI ID width
- ADDR_W, 32, address width
- DATA_W, 64, data width
- OUTSTD, 4, B-route FIFO depth = max writes awaiting B (power of 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_awvalid_i/m_awready_o  in/out  NUM_MST  per-master AW handshake
- m_awid_i  in  NUM_MST*ID_W
- m_awaddr_i  in  NUM_MST*ADDR_W
- m_awlen_i  in  NUM_MST*8
- m_awsize_i  in  NUM_MST*3
- m_awburst_i  in  NUM_MST*2
- m_wvalid_i/m_wready_o  in/out  NUM_MST  per-master W handshake
- m_wdata_i  in  NUM_MST*DATA_W
- m_wstrb_i  in  NUM_MST*DATA_W/8
- m_wlast_i  in  NUM_MST
- m_bvalid_o/m_bready_i  out/in  NUM_MST
- m_bid_o  out  ID_W  broadcast; qualified by m_bvalid_o
- m_bresp_o  out  2  broadcast
- s_awvalid_o/s_awready_i, s_awid_o, s_awaddr_o, s_awlen_o, s_awsize_o, s_awburst_o  downstream AW, same widths per master
- s_wvalid_o/s_wready_i, s_wdata_o, s_wstrb_o, s_wlast_o  downstream W
- s_bvalid_i/s_bready_o, s_bid_i, s_bresp_i  downstream B
- err_o  out  1  sticky protocol-error flag

Behaviour:
- FSM states IDLE, ADDR, DATA. Reset: IDLE, grant ptr 0, rr priority ptr 0, FIFO empty, beat cnt 0, err_o 0, all valid/ready outputs 0.
- IDLE: if any m_awvalid_i and FIFO not full, register grant = first requester at or after rr ptr (wrapping); go ADDR.
  - FIFO full: stay IDLE, no grant.
- ADDR: s_aw* = granted master's fields; s_awvalid_o = m_awvalid_i[g]; m_awready_o[g] = s_awready_i, all others 0.
  - On handshake: latch awlen, push g into FIFO, rr ptr = g+1 mod NUM_MST, beat cnt 0, go DATA.
  - Minimum latency: request at cycle N, s_awvalid_o at N+1.
- DATA: s_w* = master g's W, except s_wlast_o = (cnt == latched awlen); m_wready_o[g] = s_wready_i, others 0.
  - Each W handshake increments cnt.
  - Handshake with cnt == awlen: go IDLE.
  - Earliest next grant is the cycle after that.
- Non-granted masters see all ready outputs 0. W before AW from the same master is held (not forwarded) until DATA.
- B routing: FIFO head h, when not empty, drives m_bvalid_o[h] = s_bvalid_i and s_bready_o = m_bready_i[h]; pop on handshake.
  - FIFO empty: s_bready_o = 0, all m_bvalid_o = 0.
  - Downstream slave returns B in AW acceptance order (requirement on slave).
- Push and pop in the same cycle: both take effect, count unchanged. Full + simultaneous pop does not allow a grant that cycle; full is evaluated on registered count.
- err_o set, and held until reset, when any of:
  - m_wlast_i[g] != s_wlast_o on a W handshake;
  - awburst == 2'b11 (reserved) accepted;
  - awburst == WRAP with awlen not in {1,3,7,15}.
  - Traffic is still forwarded unchanged.
- Reset mid-burst: all state cleared asynchronously; outputs return to reset values immediately.

Test Plan:
- Single write: master 1 AW len=3 INCR addr 0x100 → s_awvalid_o next cycle, 4 W beats forwarded, s_wlast_o only on beat 4, B bresp 00 on m_bvalid_o[1] only.
- Fairness: all 4 masters request continuously, len=0 each → grants in order 0,1,2,3,0; no master granted twice before others.
- Back-pressure: OUTSTD=4, s_bvalid_i held 0, 5 requests → exactly 4 AW accepted, 5th stalls; one B handshake → 5th granted; B returned to masters in grant order.
- Protocol error: master asserts m_wlast_i on beat 2 of len=3 burst → err_o=1 next cycle and stays 1; 4 beats still forwarded.
- Reserved burst: awburst=2'b11 → forwarded, err_o=1. WRAP len=2 → err_o=1.
- Reset mid-burst: rst_n low during beat 2 → all valid/ready outputs 0 at once; after release, new request from master 3 granted first (rr ptr 0 scan).
